// File: rtl/frequency_generator_pkg.sv
// Shared constants for the PicoBlaze-writable NCO: register offsets, CTRL bit
// positions, FTW width and the commit FSM state type.
package frequency_generator_pkg;

  localparam int FTW_W = 32;

  // Window offsets relative to BASE; FTW3 holds the most significant byte.
  localparam logic [7:0] OFS_FTW3 = 8'd0;
  localparam logic [7:0] OFS_FTW2 = 8'd1;
  localparam logic [7:0] OFS_FTW1 = 8'd2;
  localparam logic [7:0] OFS_FTW0 = 8'd3;
  localparam logic [7:0] OFS_CTRL = 8'd4;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_ARM     = 1;
  localparam int CTRL_EN      = 2;
  localparam int CTRL_PPS_CLR = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

endpackage

// File: rtl/frequency_generator_pps.sv
// pps_sync: multi-flop synchronizer for the asynchronous 1PPS input followed by
// a rising-edge detector; pps_rise is a 1-clk pulse SYNC_STAGES clocks after the edge.
module pps_sync #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pps,
  output logic pps_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pps};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pps_rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/frequency_generator.sv
// NCO square-wave source with a byte-wide KCPSM write window and an optional
// PPS-aligned FTW commit. Optional readback: FREQUENCY_GENERATOR_READBACK_EN.
module frequency_generator
  import frequency_generator_pkg::*;
#(
  parameter int BASE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pps,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
`ifdef FREQUENCY_GENERATOR_READBACK_EN
  input  logic       read_strobe,
  output logic [7:0] in_port,
`endif
  output logic       fout,
  output logic       armed
);

  state_e             state_q, state_d;
  logic [FTW_W-1:0]   staging_q, ftw_q, acc_q;
  logic               en_q, clr_q, fout_q;
  logic               pps_rise;
  logic [7:0]         ofs;
  logic               ctrl_wr, commit, arm_req;
  logic               load_ftw, clr_acc;

  pps_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pps_sync (
    .clk      (clk),
    .reset    (reset),
    .pps      (pps),
    .pps_rise (pps_rise)
  );

  assign ofs     = port_id - 8'(BASE);
  assign ctrl_wr = write_strobe && (ofs == OFS_CTRL);
  assign commit  = ctrl_wr && out_port[CTRL_COMMIT];
  assign arm_req = ctrl_wr && out_port[CTRL_ARM] && !out_port[CTRL_COMMIT];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    load_ftw = 1'b0;
    clr_acc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit)       load_ftw = 1'b1;
        else if (arm_req) state_d  = ARMED;
      end
      ARMED: begin
        if (commit) begin
          load_ftw = 1'b1;
          state_d  = IDLE;
        end else if (pps_rise) begin
          load_ftw = 1'b1;
          clr_acc  = clr_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      staging_q <= '0;
      ftw_q     <= '0;
      acc_q     <= '0;
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      fout_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (write_strobe) begin
        case (ofs)
          OFS_FTW3: staging_q[31:24] <= out_port;
          OFS_FTW2: staging_q[23:16] <= out_port;
          OFS_FTW1: staging_q[15:8]  <= out_port;
          OFS_FTW0: staging_q[7:0]   <= out_port;
          default: ;
        endcase
      end
      // NOTE: non-blocking updates mean a commit on the same edge as a staging
      // byte write captures the old staging value.
      if (load_ftw) ftw_q <= staging_q;
      if (ctrl_wr) begin
        en_q  <= out_port[CTRL_EN];
        clr_q <= out_port[CTRL_PPS_CLR];
      end
      if (!en_q || clr_acc) acc_q <= '0;
      else                  acc_q <= acc_q + ftw_q;
      fout_q <= acc_q[FTW_W-1] & en_q;
    end
  end

  assign fout  = fout_q;
  assign armed = (state_q == ARMED);

`ifdef FREQUENCY_GENERATOR_READBACK_EN
  // Reads decode on port_id alone; the bus floats outside the window.
  always_comb begin
    in_port = 8'bz;
    case (ofs)
      OFS_FTW3: in_port = ftw_q[31:24];
      OFS_FTW2: in_port = ftw_q[23:16];
      OFS_FTW1: in_port = ftw_q[15:8];
      OFS_FTW0: in_port = ftw_q[7:0];
      OFS_CTRL: in_port = {4'b0, clr_q, en_q, armed, 1'b0};
      default:  in_port = 8'bz;
    endcase
  end
`endif

endmodule
